// File: rtl/otter_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// otter_hazard_ctrl
//   Hazard and forwarding controller for the 5-stage OTTER pipeline
//   (IF/DE/EX/MEM/WB). It produces:
//     - per-stage pipeline register write-enables (pc, IF/DE, DE/EX, EX/MEM, MEM/WB)
//     - IF/DE flush, DE/EX bubble and MEM/WB bubble requests
//     - EX-stage operand forwarding selects (0 = RF, 1 = MEM, 2 = WB) and data
//   A small RUN/WAIT FSM freezes the front of the pipe while a slow data-memory
//   access in MEM completes (MEM_LAT-1 stall cycles per access).
//
// Parameters
//   XLEN     forwarded operand width
//   RA_W     register address width
//   MEM_LAT  data-memory latency in cycles (>= 1)
//
// Ports
//   CLK, RESET                         clock, synchronous active-high reset
//   de_rs{1,2}_addr / _used            DE-stage sources
//   ex_rs{1,2}_addr / _used            EX-stage sources
//   ex_rd_addr, ex_regwrite, ex_memread, ex_valid, ex_branch_taken
//   mem_rd_addr, mem_regwrite, mem_access, mem_valid
//   wb_rd_addr, wb_regwrite, wb_valid
//   ex_rs{1,2}_rf, mem_alu_result, wb_data   forwarding data sources
//   pc_write .. mem_wb_write           pipeline register enables
//   if_de_flush, de_ex_bubble, mem_wb_bubble
//   fwd_{a,b}_sel, fwd_{a,b}_data      EX operand forwarding
//
// Optional build macro HAZARD_PERF_EN adds 32-bit saturating counters
//   stall_cycles, loaduse_cycles, flush_count.
// -----------------------------------------------------------------------------
module otter_hazard_ctrl #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int MEM_LAT = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [RA_W-1:0] de_rs1_addr,
  input  logic [RA_W-1:0] de_rs2_addr,
  input  logic            de_rs1_used,
  input  logic            de_rs2_used,
  input  logic [RA_W-1:0] ex_rs1_addr,
  input  logic [RA_W-1:0] ex_rs2_addr,
  input  logic            ex_rs1_used,
  input  logic            ex_rs2_used,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_valid,
  input  logic            ex_branch_taken,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_regwrite,
  input  logic            mem_access,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_regwrite,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] ex_rs1_rf,
  input  logic [XLEN-1:0] ex_rs2_rf,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] wb_data,
  output logic            pc_write,
  output logic            if_de_write,
  output logic            de_ex_write,
  output logic            ex_mem_write,
  output logic            mem_wb_write,
  output logic            if_de_flush,
  output logic            de_ex_bubble,
  output logic            mem_wb_bubble,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic [XLEN-1:0] fwd_a_data,
  output logic [XLEN-1:0] fwd_b_data
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     loaduse_cycles,
  output logic [31:0]     flush_count
`endif
);

  localparam bit MULTI_CYC = (MEM_LAT > 1);
  localparam int CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int LOAD_I    = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_full_stall;
  logic             w_flush;
  logic             w_loaduse;
  logic             w_lu_hazard;
  logic             w_a_mem, w_a_wb, w_b_mem, w_b_wb;

  // Producer stage X supplies source rs when it really writes a nonzero rd.
  function automatic logic stage_hit(input logic            v,
                                     input logic            rw,
                                     input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] rs,
                                     input logic            used);
    return v && rw && (rd != '0) && (rd == rs) && used;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // A load in MEM has no data yet, so its MEM hit must not be forwarded.
  assign w_a_mem = stage_hit(mem_valid, mem_regwrite, mem_rd_addr, ex_rs1_addr, ex_rs1_used) && !mem_access;
  assign w_b_mem = stage_hit(mem_valid, mem_regwrite, mem_rd_addr, ex_rs2_addr, ex_rs2_used) && !mem_access;
  assign w_a_wb  = stage_hit(wb_valid, wb_regwrite, wb_rd_addr, ex_rs1_addr, ex_rs1_used);
  assign w_b_wb  = stage_hit(wb_valid, wb_regwrite, wb_rd_addr, ex_rs2_addr, ex_rs2_used);

  assign w_lu_hazard = ex_valid && ex_memread && ex_regwrite && (ex_rd_addr != '0) &&
                       (((ex_rd_addr == de_rs1_addr) && de_rs1_used) ||
                        ((ex_rd_addr == de_rs2_addr) && de_rs2_used));

  // ---- stage boundary: FSM state register ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_full_stall  = 1'b0;
    pc_write      = 1'b1;
    if_de_write   = 1'b1;
    de_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    if_de_flush   = 1'b0;
    de_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (MULTI_CYC && mem_valid && mem_access) begin
          w_full_stall = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_full_stall = 1'b1;
          w_cnt_nxt    = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    // Memory stall dominates; a taken branch discards the stalled DE
    // instruction, so it dominates load-use.
    w_flush   = !w_full_stall && ex_branch_taken;
    w_loaduse = !w_full_stall && !w_flush && w_lu_hazard;

    if (RESET) begin
      w_full_stall = 1'b0;
      w_flush      = 1'b0;
      w_loaduse    = 1'b0;
    end

    if (w_full_stall) begin
      pc_write      = 1'b0;
      if_de_write   = 1'b0;
      de_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (w_flush) begin
      if_de_flush  = 1'b1;
      de_ex_bubble = 1'b1;
    end else if (w_loaduse) begin
      pc_write     = 1'b0;
      if_de_write  = 1'b0;
      de_ex_bubble = 1'b1;
    end
  end

  // ---- stage boundary: EX operand forwarding (combinational) ----
  always_comb begin
    fwd_a_sel  = 2'd0;
    fwd_a_data = ex_rs1_rf;
    fwd_b_sel  = 2'd0;
    fwd_b_data = ex_rs2_rf;
    if (!RESET) begin
      if (w_a_mem) begin
        fwd_a_sel  = 2'd1;
        fwd_a_data = mem_alu_result;
      end else if (w_a_wb) begin
        fwd_a_sel  = 2'd2;
        fwd_a_data = wb_data;
      end
      if (w_b_mem) begin
        fwd_b_sel  = 2'd1;
        fwd_b_data = mem_alu_result;
      end else if (w_b_wb) begin
        fwd_b_sel  = 2'd2;
        fwd_b_data = wb_data;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_loaduse_cycles;
  logic [31:0] r_flush_count;

  // ---- stage boundary: performance counters ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cycles   <= '0;
      r_loaduse_cycles <= '0;
      r_flush_count    <= '0;
    end else begin
      if (w_full_stall) r_stall_cycles   <= sat_inc(r_stall_cycles);
      if (w_loaduse)    r_loaduse_cycles <= sat_inc(r_loaduse_cycles);
      if (w_flush)      r_flush_count    <= sat_inc(r_flush_count);
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign loaduse_cycles = r_loaduse_cycles;
  assign flush_count    = r_flush_count;
`endif

endmodule
